// File: rtl/hssaer_pkg.sv
// Shared definitions for the HSSAER transmit path.
package hssaer_pkg;
  localparam int HSSAER_MAX_NCH = 8;

  // Ceiling log2, never below 1 so single-entry indices still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/hssaer_tx.sv
// Serialiser: start bit, DSIZE data bits LSB first, even parity; tx retimed on clkn.
// Latency: frame starts the edge after st rises; waits in HOLD for st to drop before re-arming.
module hssaer_tx #(
  parameter int DSIZE = 8
) (
  input  logic             clkp,
  input  logic             clkn,
  input  logic             _rst,
  input  logic             st,
  input  logic [DSIZE-1:0] d,
  input  logic             keepalive,
  output logic             tx,
  output logic             run,
  output logic             last,
  output logic             first
);
  localparam int CW = hssaer_pkg::clog2(DSIZE + 2);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [DSIZE+1:0] sh;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      state <= S_IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (st) begin
          sh    <= {^d, d, 1'b1};
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          sh  <= sh >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DSIZE + 1)) state <= S_HOLD;
        end
        S_HOLD: if (!st) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Half-cycle retiming keeps the pin stable around the clkp edge.
  always_ff @(posedge clkn or negedge _rst) begin
    if (!_rst) tx <= 1'b0;
    else       tx <= (state == S_SEND) && sh[0];
  end

  assign first = (state == S_SEND);
  assign last  = first && (cnt == CW'(DSIZE + 1));
  assign run   = (state != S_IDLE) || keepalive;
endmodule

// File: rtl/hssaer_tx_lane.sv
// One serial lane: holds the granted event until its frame has been sent.
// Released on the first cycle after the serialiser's frame flag falls.
module hssaer_tx_lane #(
  parameter int DSIZE = 8
) (
  input  logic             clkp,
  input  logic             clkn,
  input  logic             _rst,
  input  logic             load,
  input  logic [DSIZE-1:0] din,
  input  logic             keepalive,
  output logic             idle,
  output logic             tx,
  output logic             run,
  output logic             last
);
  logic             s;
  logic             firsto;
  logic             first;
  logic [DSIZE-1:0] d;

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      s      <= 1'b0;
      d      <= '0;
      firsto <= 1'b0;
    end else if (!s) begin
      if (load) begin
        s <= 1'b1;
        d <= din;
      end
    end else begin
      firsto <= first;
      s      <= !(firsto && !first);
    end
  end

  assign idle = !s;

  hssaer_tx #(.DSIZE(DSIZE)) u_tx (
    .clkp      (clkp),
    .clkn      (clkn),
    ._rst      (_rst),
    .st        (s),
    .d         (d),
    .keepalive (keepalive),
    .tx        (tx),
    .run       (run),
    .last      (last),
    .first     (first)
  );
endmodule

// File: rtl/hssaer_paer_tx_mc.sv
// Buffered PAER-to-HSSAER transmitter: FIFO of 2**AW events dispatched round-robin to NCH lanes.
// An accepted event can be granted one edge later; dst_rdy is registered and drops at full.
module hssaer_paer_tx_mc
  import hssaer_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int NCH   = 4,
  parameter int AW    = 4
) (
  input  logic             clkp,
  input  logic             clkn,
  input  logic             _rst,
  input  logic [DSIZE-1:0] ae,
  input  logic             src_rdy,
  output logic             dst_rdy,
  input  logic             keepalive,
  input  logic [NCH-1:0]   lane_en,
  output logic [NCH-1:0]   tx,
  output logic [NCH-1:0]   run,
  output logic [NCH-1:0]   last,
  output logic [AW:0]      fifo_level,
  output logic             busy
);
  localparam int DEPTH = 1 << AW;
  localparam int RW    = clog2(NCH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level, level_nxt;
  logic [NCH-1:0]   idle, elig, grant;
  logic [RW-1:0]    rr, rr_nxt, idx;
  logic [RW:0]      sum;
  logic             push, pop;

  assign push      = src_rdy && dst_rdy;
  assign elig      = lane_en & idle;
  assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);

  // First eligible lane at or after rr, wrapping modulo NCH.
  always_comb begin
    grant  = '0;
    pop    = 1'b0;
    rr_nxt = rr;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, rr} + (RW+1)'(k);
      if (sum >= (RW+1)'(NCH)) sum = sum - (RW+1)'(NCH);
      idx = sum[RW-1:0];
      if (!pop && elig[idx] && (level != '0)) begin
        pop        = 1'b1;
        grant[idx] = 1'b1;
        rr_nxt     = (int'(idx) == NCH - 1) ? '0 : idx + RW'(1);
      end
    end
  end

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      dst_rdy <= 1'b0;
      rr      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_nxt;
      dst_rdy <= (level_nxt != (AW+1)'(DEPTH));
      rr      <= rr_nxt;
    end
  end

  always_ff @(posedge clkp) begin
    if (push) mem[wr_ptr] <= ae;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    hssaer_tx_lane #(.DSIZE(DSIZE)) u_lane (
      .clkp      (clkp),
      .clkn      (clkn),
      ._rst      (_rst),
      .load      (grant[i]),
      .din       (mem[rd_ptr]),
      .keepalive (keepalive),
      .idle      (idle[i]),
      .tx        (tx[i]),
      .run       (run[i]),
      .last      (last[i])
    );
  end

  assign fifo_level = level;
  assign busy       = (level != '0) || !(&idle);
endmodule

// File: tb/tb_hssaer_paer_tx_mc.sv
// Directed bench: decodes every lane's serial frames and checks lane assignment and order.
module tb_hssaer_paer_tx_mc;
  localparam int DSIZE = 8;
  localparam int NCH   = 4;
  localparam int AW    = 4;

  logic             clkp = 1'b0;
  logic             clkn;
  logic             _rst;
  logic [DSIZE-1:0] ae;
  logic             src_rdy;
  logic             dst_rdy;
  logic             keepalive;
  logic [NCH-1:0]   lane_en;
  logic [NCH-1:0]   tx, run, last;
  logic [AW:0]      fifo_level;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clkp = ~clkp;
  assign clkn = ~clkp;

  hssaer_paer_tx_mc #(.DSIZE(DSIZE), .NCH(NCH), .AW(AW)) dut (
    .clkp(clkp), .clkn(clkn), ._rst(_rst), .ae(ae), .src_rdy(src_rdy), .dst_rdy(dst_rdy),
    .keepalive(keepalive), .lane_en(lane_en), .tx(tx), .run(run), .last(last),
    .fifo_level(fifo_level), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame decoder: {lane, data} per completed frame.
  logic [10:0]      rxlog[$];
  bit               in_frame [NCH];
  int               bitn     [NCH];
  logic [DSIZE-1:0] rxd      [NCH];

  always @(posedge clkp) begin
    for (int i = 0; i < NCH; i++) begin
      if (!_rst) begin
        in_frame[i] = 1'b0;
      end else if (!in_frame[i]) begin
        if (tx[i]) begin
          in_frame[i] = 1'b1;
          bitn[i]     = 0;
        end
      end else begin
        bitn[i]++;
        if (bitn[i] <= DSIZE) begin
          rxd[i] = {tx[i], rxd[i][DSIZE-1:1]};
        end else begin
          chk("parity", tx[i], ^rxd[i]);
          rxlog.push_back({3'(i), rxd[i]});
          in_frame[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  task automatic do_reset();
    _rst    = 1'b0;
    src_rdy = 1'b0;
    tick();
    tick();
    _rst = 1'b1;
    tick();
    rxlog.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (rxlog.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, rxlog.size(), n);
  endtask

  task automatic chk_ev(input logic [7:0] v, input int lane);
    int cnt;
    int ln;
    cnt = 0;
    ln  = -1;
    foreach (rxlog[k]) begin
      if (rxlog[k][7:0] == v) begin
        cnt++;
        ln = int'(rxlog[k][10:8]);
      end
    end
    chk($sformatf("count_%02h", v), cnt, 1);
    chk($sformatf("lane_%02h", v), ln, lane);
  endtask

  initial begin
    logic [7:0] v;
    int         acc;

    // 1: reset
    _rst = 1'b0; src_rdy = 1'b1; ae = '0; keepalive = 1'b0; lane_en = 4'hF;
    repeat (5) tick();
    chk("rst_dst_rdy", dst_rdy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx", tx, 0);
    chk("rst_run", run, 0);
    src_rdy = 1'b0;
    _rst    = 1'b1;
    tick();
    chk("rel_dst_rdy", dst_rdy, 1);
    chk("rel_level", fifo_level, 0);

    // 2: single event, grant one edge after acceptance
    ae = 8'hA5; src_rdy = 1'b1;
    tick();
    src_rdy = 1'b0;
    chk("t2_level_n", fifo_level, 1);
    tick();
    chk("t2_level_n1", fifo_level, 0);
    chk("t2_busy_n1", busy, 1);
    tick();
    chk("t2_run_n2", run, 4'b0001);
    wait_frames(1, 100, "t2_frames");
    chk("t2_entry", rxlog[0], {3'd0, 8'hA5});
    repeat (5) tick();
    chk("t2_busy_done", busy, 0);
    chk("t2_frames_total", rxlog.size(), 1);

    // 3: round robin over 8 back-to-back events
    do_reset();
    src_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ae = 8'(k);
      tick();
    end
    src_rdy = 1'b0;
    chk("t3_level", fifo_level, 4);
    wait_frames(8, 600, "t3_frames");
    for (int k = 1; k <= 8; k++) chk_ev(8'(k), (k - 1) % 4);
    repeat (5) tick();
    chk("t3_busy_done", busy, 0);

    // 4: fill with all lanes disabled, then drain on lane 0
    do_reset();
    lane_en = 4'h0;
    acc     = 0;
    src_rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ae = 8'(16 + k);
      if (dst_rdy) acc++;
      tick();
    end
    src_rdy = 1'b0;
    chk("t4_accepted", acc, 16);
    chk("t4_level_full", fifo_level, 16);
    chk("t4_dst_rdy_full", dst_rdy, 0);
    lane_en = 4'h1;
    tick();
    chk("t4_level_pop", fifo_level, 15);
    chk("t4_dst_rdy_pop", dst_rdy, 1);
    wait_frames(16, 800, "t4_frames");
    for (int k = 0; k < 16; k++) begin
      v = 8'(16 + k);
      chk($sformatf("t4_order_%0d", k), rxlog[k], {3'd0, v});
    end

    // 5: disable lane 1 while it holds an event
    do_reset();
    lane_en = 4'hF;
    src_rdy = 1'b1;
    ae = 8'h51; tick();
    ae = 8'h52; tick();
    src_rdy = 1'b0;
    tick();
    lane_en = 4'b1101;
    src_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ae = 8'(8'h61 + k);
      tick();
    end
    src_rdy = 1'b0;
    wait_frames(6, 600, "t5_frames");
    chk_ev(8'h51, 0);
    chk_ev(8'h52, 1);
    chk_ev(8'h61, 2);
    chk_ev(8'h62, 3);
    chk_ev(8'h63, 0);
    chk_ev(8'h64, 2);

    // 6: asynchronous reset with events queued and all lanes loaded
    do_reset();
    lane_en = 4'hF;
    src_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      ae = 8'(8'h71 + k);
      tick();
    end
    src_rdy = 1'b0;
    chk("t6_level", fifo_level, 5);
    chk("t6_busy", busy, 1);
    chk("t6_run", run, 4'hF);
    _rst = 1'b0;
    #1;
    chk("t6_arst_level", fifo_level, 0);
    chk("t6_arst_busy", busy, 0);
    chk("t6_arst_dst_rdy", dst_rdy, 0);
    chk("t6_arst_run", run, 0);
    chk("t6_arst_tx", tx, 0);
    tick();
    tick();
    _rst = 1'b1;
    tick();
    rxlog.delete();
    ae = 8'h3C; src_rdy = 1'b1;
    tick();
    src_rdy = 1'b0;
    wait_frames(1, 100, "t6_frames");
    chk("t6_entry", rxlog[0], {3'd0, 8'h3C});
    repeat (20) tick();
    chk("t6_frames_total", rxlog.size(), 1);
    chk("t6_busy_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
